// File: rtl/rx_lt_extract.sv
// rx_lt_extract
//   Pulls the Length/Type field, and for VLAN-tagged frames the inner length,
//   out of the header words of a 64-bit receive stream.
//
//   Word 0 is flagged by rx_start (DA bytes 0-5, SA bytes 6-7). Word 1
//   carries the outer Length/Type in bytes 12,13. For tagged frames
//   (outer LT 16'h8100), word 2 carries the inner length in bytes 16,17.
//   Captured fields stay valid through rx_end until the next rx_start, so
//   downstream length checks see stable values at the end of the frame.
//
//   Ports
//     rxclk         in   receive clock
//     reset_n       in   synchronous active-low reset
//     rx_data       in   frame word, byte n on bits [8n+7:8n]
//     rx_data_valid in   word qualifier; without it the FSM stalls
//     rx_start      in   first word of frame
//     rx_end        in   last word of frame
//     lt_data       out  outer Length/Type
//     tagged_len    out  inner length of a VLAN-tagged frame
//     tagged_frame  out  outer LT == 16'h8100
//     pause_frame   out  pause frame detected (untagged only)
//     lt_valid      out  fields stable for the current frame
//     lt_strobe     out  one-cycle capture-complete pulse
//     hdr_short     out  one-cycle pulse, frame ended before header complete
//
//   Build option
//     RX_PAUSE_DA_CHECK_EN  pause detection also requires DA 01-80-C2-00-00-01
//                           and MAC control opcode 16'h0001; without it only
//                           the outer LT (16'h8808) is checked.
//
//   state | meaning
//   ------+---------------------------------------------
//   IDLE  | no frame in progress, words ignored
//   W1    | waiting for word 1 (outer Length/Type)
//   W2    | waiting for word 2 (inner length, tagged only)
//   HOLD  | fields valid, waiting for frame end

module rx_lt_extract (
    input  logic        rxclk,
    input  logic        reset_n,
    input  logic [63:0] rx_data,
    input  logic        rx_data_valid,
    input  logic        rx_start,
    input  logic        rx_end,
    output logic [15:0] lt_data,
    output logic [15:0] tagged_len,
    output logic        tagged_frame,
    output logic        pause_frame,
    output logic        lt_valid,
    output logic        lt_strobe,
    output logic        hdr_short
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        W1   = 2'd1,
        W2   = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t state;

    logic [15:0] lt_word;
    logic [15:0] len_word;
    logic        is_tagged;
    logic        pause_hit;

    // Network byte order: lower-numbered byte is the most significant.
    assign lt_word   = {rx_data[39:32], rx_data[47:40]};
    assign len_word  = {rx_data[7:0],   rx_data[15:8]};
    assign is_tagged = (lt_word == 16'h8100);

`ifdef RX_PAUSE_DA_CHECK_EN
    logic        da_match;
    logic        da_hit;
    logic [15:0] opcode_word;

    // DA 01-80-C2-00-00-01 with byte 0 in the low bits of word 0.
    assign da_hit      = (rx_data[47:0] == 48'h01_00_00_C2_80_01);
    assign opcode_word = {rx_data[55:48], rx_data[63:56]};
    assign pause_hit   = (lt_word == 16'h8808) && da_match &&
                         (opcode_word == 16'h0001);

    // Only the match result of word 0 is kept, not the address itself.
    always_ff @(posedge rxclk) begin
        if (!reset_n) begin
            da_match <= 1'b0;
        end else if (rx_data_valid && rx_start) begin
            da_match <= da_hit;
        end
    end
`else
    logic unused_bytes;

    assign pause_hit    = (lt_word == 16'h8808);
    assign unused_bytes = ^{rx_data[63:48], rx_data[31:16]};
`endif

    always_ff @(posedge rxclk) begin
        if (!reset_n) begin
            state        <= IDLE;
            lt_data      <= 16'h0000;
            tagged_len   <= 16'h0000;
            tagged_frame <= 1'b0;
            pause_frame  <= 1'b0;
            lt_valid     <= 1'b0;
            lt_strobe    <= 1'b0;
            hdr_short    <= 1'b0;
        end else begin
            lt_strobe <= 1'b0;
            hdr_short <= 1'b0;

            if (rx_data_valid) begin
                if (rx_start) begin
                    // A restart drops whatever frame was in flight without
                    // reporting it; only a start+end word is a short header.
                    lt_data      <= 16'h0000;
                    tagged_len   <= 16'h0000;
                    tagged_frame <= 1'b0;
                    pause_frame  <= 1'b0;
                    lt_valid     <= 1'b0;
                    if (rx_end) begin
                        hdr_short <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        state     <= W1;
                    end
                end else begin
                    case (state)
                        W1: begin
                            if (is_tagged) begin
                                if (rx_end) begin
                                    // Tag seen but inner length never arrives.
                                    hdr_short    <= 1'b1;
                                    lt_data      <= 16'h0000;
                                    tagged_frame <= 1'b0;
                                    state        <= IDLE;
                                end else begin
                                    lt_data      <= lt_word;
                                    tagged_frame <= 1'b1;
                                    state        <= W2;
                                end
                            end else begin
                                lt_data      <= lt_word;
                                tagged_frame <= 1'b0;
                                pause_frame  <= pause_hit;
                                lt_valid     <= 1'b1;
                                lt_strobe    <= 1'b1;
                                state        <= rx_end ? IDLE : HOLD;
                            end
                        end
                        W2: begin
                            // Word 2 always carries the inner length, so an
                            // rx_end here still completes the capture.
                            tagged_len <= len_word;
                            lt_valid   <= 1'b1;
                            lt_strobe  <= 1'b1;
                            state      <= rx_end ? IDLE : HOLD;
                        end
                        HOLD: begin
                            if (rx_end) begin
                                state <= IDLE;
                            end
                        end
                        default: begin
                            state <= IDLE;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_rx_lt_extract.sv
// Directed bench for rx_lt_extract. Outputs are sampled 1 time unit after
// the rising edge that consumed each driven word, and compared as one packed
// vector {lt_data, tagged_len, tagged_frame, pause_frame, lt_valid,
// lt_strobe, hdr_short}.

module tb_rx_lt_extract;

    logic        rxclk;
    logic        reset_n;
    logic [63:0] rx_data;
    logic        rx_data_valid;
    logic        rx_start;
    logic        rx_end;
    logic [15:0] lt_data;
    logic [15:0] tagged_len;
    logic        tagged_frame;
    logic        pause_frame;
    logic        lt_valid;
    logic        lt_strobe;
    logic        hdr_short;

    logic [36:0] outs;
    logic [36:0] exp_v;
    int          checks;
    int          errors;

    localparam logic [63:0] DA_PAUSE = 64'h0000_0100_00C2_8001;
    localparam logic [63:0] DA_OTHER = 64'h0000_0200_00C2_8001;
    localparam logic [63:0] DA_PLAIN = 64'h3322_5544_3322_1100;

`ifdef RX_PAUSE_DA_CHECK_EN
    localparam logic BAD_DA_PAUSE = 1'b0;
`else
    localparam logic BAD_DA_PAUSE = 1'b1;
`endif

    rx_lt_extract dut (
        .rxclk         (rxclk),
        .reset_n       (reset_n),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid),
        .rx_start      (rx_start),
        .rx_end        (rx_end),
        .lt_data       (lt_data),
        .tagged_len    (tagged_len),
        .tagged_frame  (tagged_frame),
        .pause_frame   (pause_frame),
        .lt_valid      (lt_valid),
        .lt_strobe     (lt_strobe),
        .hdr_short     (hdr_short)
    );

    assign outs = {lt_data, tagged_len, tagged_frame, pause_frame,
                   lt_valid, lt_strobe, hdr_short};

    initial begin
        rxclk = 1'b0;
        forever #5 rxclk = ~rxclk;
    end

    function automatic logic [63:0] mk_w1(input logic [15:0] lt,
                                          input logic [15:0] op);
        logic [63:0] w;
        w        = 64'h00AA_00BB_0000_0000;
        w[39:32] = lt[15:8];
        w[47:40] = lt[7:0];
        w[55:48] = op[15:8];
        w[63:56] = op[7:0];
        return w;
    endfunction

    function automatic logic [63:0] mk_w2(input logic [15:0] len);
        logic [63:0] w;
        w       = 64'h1111_2222_3333_0000;
        w[7:0]  = len[15:8];
        w[15:8] = len[7:0];
        return w;
    endfunction

    task automatic drive(input logic [63:0] d, input logic v,
                         input logic s, input logic e);
        rx_data       = d;
        rx_data_valid = v;
        rx_start      = s;
        rx_end        = e;
        @(posedge rxclk);
        #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        drive(DA_PLAIN, 1'b1, 1'b1, 1'b0);
        drive(mk_w1(16'h8808, 16'h0001), 1'b1, 1'b0, 1'b0);
        checks++;
        if (outs !== 37'h0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp %h", outs, 37'h0);
        end
        reset_n = 1'b1;
        drive(mk_w1(16'h05DC, 16'h0000), 1'b1, 1'b0, 1'b0);
        checks++;
        if (outs !== 37'h0) begin
            errors++;
            $display("FAIL reset_no_resume got %h exp %h", outs, 37'h0);
        end
    endtask

    task automatic test_untagged;
        drive(DA_PLAIN, 1'b1, 1'b1, 1'b0);
        checks++;
        if (outs !== 37'h0) begin
            errors++;
            $display("FAIL untagged_w0 got %h exp %h", outs, 37'h0);
        end
        drive(mk_w1(16'h05DC, 16'h1234), 1'b1, 1'b0, 1'b0);
        exp_v = {16'h05DC, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        checks++;
        if (outs !== exp_v) begin
            errors++;
            $display("FAIL untagged_w1 got %h exp %h", outs, exp_v);
        end
        drive(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1);
        exp_v = {16'h05DC, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        checks++;
        if (outs !== exp_v) begin
            errors++;
            $display("FAIL untagged_end got %h exp %h", outs, exp_v);
        end
        drive(64'h0, 1'b0, 1'b0, 1'b0);
        drive(mk_w1(16'h0800, 16'h0000), 1'b1, 1'b0, 1'b0);
        checks++;
        if (outs !== exp_v) begin
            errors++;
            $display("FAIL untagged_hold_idle got %h exp %h", outs, exp_v);
        end
    endtask

    task automatic test_tagged_gap;
        drive(DA_PLAIN, 1'b1, 1'b1, 1'b0);
        drive(mk_w1(16'h8100, 16'h0005), 1'b1, 1'b0, 1'b0);
        exp_v = {16'h8100, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        checks++;
        if (outs !== exp_v) begin
            errors++;
            $display("FAIL tagged_w1 got %h exp %h", outs, exp_v);
        end
        drive(mk_w2(16'h9999), 1'b0, 1'b0, 1'b0);
        checks++;
        if (outs !== exp_v) begin
            errors++;
            $display("FAIL tagged_gap got %h exp %h", outs, exp_v);
        end
        drive(mk_w2(16'h002E), 1'b1, 1'b0, 1'b0);
        exp_v = {16'h8100, 16'h002E, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        checks++;
        if (outs !== exp_v) begin
            errors++;
            $display("FAIL tagged_w2 got %h exp %h", outs, exp_v);
        end
        drive(64'h0, 1'b1, 1'b0, 1'b1);
        exp_v = {16'h8100, 16'h002E, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        checks++;
        if (outs !== exp_v) begin
            errors++;
            $display("FAIL tagged_end got %h exp %h", outs, exp_v);
        end
    endtask

    task automatic test_pause;
        drive(DA_PAUSE, 1'b1, 1'b1, 1'b0);
        drive(mk_w1(16'h8808, 16'h0001), 1'b1, 1'b0, 1'b1);
        exp_v = {16'h8808, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        checks++;
        if (outs !== exp_v) begin
            errors++;
            $display("FAIL pause_good_da got %h exp %h", outs, exp_v);
        end
        drive(64'h0, 1'b0, 1'b0, 1'b0);
        exp_v = {16'h8808, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        checks++;
        if (outs !== exp_v) begin
            errors++;
            $display("FAIL pause_held got %h exp %h", outs, exp_v);
        end
        drive(DA_OTHER, 1'b1, 1'b1, 1'b0);
        checks++;
        if (outs !== 37'h0) begin
            errors++;
            $display("FAIL pause_restart_clear got %h exp %h", outs, 37'h0);
        end
        drive(mk_w1(16'h8808, 16'h0001), 1'b1, 1'b0, 1'b0);
        exp_v = {16'h8808, 16'h0000, 1'b0, BAD_DA_PAUSE, 1'b1, 1'b1, 1'b0};
        checks++;
        if (outs !== exp_v) begin
            errors++;
            $display("FAIL pause_other_da got %h exp %h", outs, exp_v);
        end
        drive(DA_PAUSE, 1'b1, 1'b1, 1'b0);
        drive(mk_w1(16'h8100, 16'h0001), 1'b1, 1'b0, 1'b0);
        drive(mk_w2(16'h8808), 1'b1, 1'b0, 1'b1);
        exp_v = {16'h8100, 16'h8808, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        checks++;
        if (outs !== exp_v) begin
            errors++;
            $display("FAIL pause_tagged_zero got %h exp %h", outs, exp_v);
        end
    endtask

    task automatic test_short;
        drive(DA_PLAIN, 1'b1, 1'b1, 1'b0);
        drive(mk_w1(16'h8100, 16'h0000), 1'b1, 1'b0, 1'b1);
        exp_v = {16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        checks++;
        if (outs !== exp_v) begin
            errors++;
            $display("FAIL short_tagged_w1 got %h exp %h", outs, exp_v);
        end
        drive(mk_w2(16'h0040), 1'b1, 1'b0, 1'b0);
        checks++;
        if (outs !== 37'h0) begin
            errors++;
            $display("FAIL short_pulse_once got %h exp %h", outs, 37'h0);
        end
        drive(DA_PLAIN, 1'b1, 1'b1, 1'b1);
        checks++;
        if (outs !== exp_v) begin
            errors++;
            $display("FAIL short_start_end got %h exp %h", outs, exp_v);
        end
        drive(64'h0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (outs !== 37'h0) begin
            errors++;
            $display("FAIL short_after got %h exp %h", outs, 37'h0);
        end
    endtask

    task automatic test_restart;
        drive(DA_PLAIN, 1'b1, 1'b1, 1'b0);
        drive(mk_w1(16'h8100, 16'h0000), 1'b1, 1'b0, 1'b0);
        drive(DA_PLAIN, 1'b1, 1'b1, 1'b0);
        checks++;
        if (outs !== 37'h0) begin
            errors++;
            $display("FAIL restart_clear got %h exp %h", outs, 37'h0);
        end
        drive(mk_w1(16'h05DC, 16'h0000), 1'b1, 1'b0, 1'b0);
        exp_v = {16'h05DC, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        checks++;
        if (outs !== exp_v) begin
            errors++;
            $display("FAIL restart_new_frame got %h exp %h", outs, exp_v);
        end
    endtask

    task automatic test_back_to_back;
        drive(DA_PLAIN, 1'b1, 1'b1, 1'b0);
        drive(mk_w1(16'h0600, 16'h0000), 1'b1, 1'b0, 1'b1);
        drive(DA_PLAIN, 1'b1, 1'b1, 1'b0);
        drive(mk_w1(16'h8100, 16'h0000), 1'b1, 1'b0, 1'b0);
        drive(mk_w2(16'h0040), 1'b1, 1'b0, 1'b1);
        exp_v = {16'h8100, 16'h0040, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        checks++;
        if (outs !== exp_v) begin
            errors++;
            $display("FAIL b2b_second got %h exp %h", outs, exp_v);
        end
        drive(mk_w2(16'h1234), 1'b1, 1'b0, 1'b0);
        exp_v = {16'h8100, 16'h0040, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        checks++;
        if (outs !== exp_v) begin
            errors++;
            $display("FAIL b2b_idle_ignore got %h exp %h", outs, exp_v);
        end
    endtask

    task automatic test_reset_mid;
        drive(DA_PLAIN, 1'b1, 1'b1, 1'b0);
        drive(mk_w1(16'h0800, 16'h0000), 1'b1, 1'b0, 1'b0);
        reset_n = 1'b0;
        drive(DA_PLAIN, 1'b1, 1'b1, 1'b0);
        checks++;
        if (outs !== 37'h0) begin
            errors++;
            $display("FAIL reset_mid got %h exp %h", outs, 37'h0);
        end
        reset_n = 1'b1;
        drive(mk_w1(16'h05DC, 16'h0000), 1'b1, 1'b0, 1'b0);
        drive(mk_w2(16'h002E), 1'b1, 1'b0, 1'b1);
        checks++;
        if (outs !== 37'h0) begin
            errors++;
            $display("FAIL reset_mid_ignore got %h exp %h", outs, 37'h0);
        end
        drive(DA_PLAIN, 1'b1, 1'b1, 1'b0);
        drive(mk_w1(16'h0800, 16'h0000), 1'b1, 1'b0, 1'b0);
        exp_v = {16'h0800, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        checks++;
        if (outs !== exp_v) begin
            errors++;
            $display("FAIL reset_mid_fresh got %h exp %h", outs, exp_v);
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset_n       = 1'b0;
        rx_data       = 64'h0;
        rx_data_valid = 1'b0;
        rx_start      = 1'b0;
        rx_end        = 1'b0;

        test_reset;
        test_untagged;
        test_tagged_gap;
        test_pause;
        test_short;
        test_restart;
        test_back_to_back;
        test_reset_mid;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
